encoder_trigger_sequencer: RTL and testbench

ENCODER_TRIGGER_SEQUENCER -- requirements
Module: encoder_trigger_sequencer

---
 rtl/encoder_pkg.sv | 17 +
 rtl/position_window_cmp.sv | 19 +
 rtl/encoder_trigger_sequencer.sv | 177 +++++++++++++++++
 tb/tb_encoder_trigger_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared state encoding and width defaults for the encoder trigger sequencer
package encoder_pkg;

  localparam int POSITION_SIZE_DEFAULT = 32;
  localparam int CNT_W_DEFAULT         = 16;

  // Encoding is visible on o_state, so keep values stable across revisions
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOMING = 3'd1,
    ST_ARMED  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/position_window_cmp.sv
// rtl/position_window_cmp.sv - signed inclusive position window comparator
import encoder_pkg::*;

module position_window_cmp #(
  parameter int POSITION_SIZE = POSITION_SIZE_DEFAULT
) (
  input  logic [POSITION_SIZE-1:0] position,
  input  logic [POSITION_SIZE-1:0] win_start,
  input  logic [POSITION_SIZE-1:0] win_stop,
  output logic                     in_window
);

  // Both bounds inclusive; all three operands are two's complement positions
  always_comb begin
    in_window = ($signed(position) >= $signed(win_start)) &&
                ($signed(position) <= $signed(win_stop));
  end

endmodule

// File: rtl/encoder_trigger_sequencer.sv
// rtl/encoder_trigger_sequencer.sv - homing, window-gated trigger sequencer for an encoder decoder
import encoder_pkg::*;

module encoder_trigger_sequencer #(
  parameter int POSITION_SIZE = POSITION_SIZE_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_aresetn,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     cfg_home_req,
  input  logic [31:0]              cfg_home_timeout,
  input  logic [POSITION_SIZE-1:0] cfg_win_start,
  input  logic [POSITION_SIZE-1:0] cfg_win_stop,
  input  logic [CNT_W-1:0]         cfg_trig_count,
  input  logic                     dec_zero_mark,
  input  logic                     dec_trigger,
  input  logic [POSITION_SIZE-1:0] dec_position,
  output logic                     o_dec_enable,
  output logic                     o_trigger,
  output logic [CNT_W-1:0]         o_trig_index,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [2:0]               o_state
);

  seq_state_e state;
  seq_state_e state_next;

  // Configuration captured at the accepted start; the run never sees cfg_* change
  logic                     lat_home_req;
  logic [31:0]              lat_home_timeout;
  logic [POSITION_SIZE-1:0] lat_win_start;
  logic [POSITION_SIZE-1:0] lat_win_stop;
  logic [CNT_W-1:0]         lat_trig_count;

  logic [31:0]              home_cnt;
  logic [31:0]              home_cnt_inc;
  logic [31:0]              home_cnt_next;
  logic [CNT_W-1:0]         idx_inc;
  logic [CNT_W-1:0]         trig_index_next;

  logic in_window;
  logic win_invalid;
  logic homed;
  logic start_ok;
  logic hit;
  logic trigger_next;
  logic done_next;
  logic busy_next;
  logic error_next;

  position_window_cmp #(
    .POSITION_SIZE(POSITION_SIZE)
  ) u_window (
    .position (dec_position),
    .win_start(lat_win_start),
    .win_stop (lat_win_stop),
    .in_window(in_window)
  );

  // Abort outranks start even in IDLE, so a simultaneous abort cancels the start
  assign start_ok     = (state == ST_IDLE) && i_start && !i_abort;
  assign win_invalid  = $signed(lat_win_start) > $signed(lat_win_stop);
  assign homed        = !lat_home_req || dec_zero_mark;
  assign home_cnt_inc = home_cnt + 32'd1;
  assign idx_inc      = o_trig_index + CNT_W'(1);
  // A trigger only counts when sampled in-window while ACTIVE and not being aborted
  assign hit          = (state == ST_ACTIVE) && in_window && dec_trigger && !i_abort;

  assign o_state = state;

  // State register
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection; abort overrides every other transition
  always_comb begin
    state_next = state;
    if ((state != ST_IDLE) && i_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) state_next = ST_HOMING;
        end
        ST_HOMING: begin
          if (win_invalid) begin
            state_next = ST_ERROR;
          end else if (homed) begin
            state_next = (lat_trig_count == '0) ? ST_DONE : ST_ARMED;
          end else if ((lat_home_timeout != 32'd0) && (home_cnt_inc == lat_home_timeout)) begin
            // HOMING lasts exactly lat_home_timeout cycles before giving up
            state_next = ST_ERROR;
          end
        end
        ST_ARMED: begin
          if (in_window) state_next = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!in_window) begin
            state_next = ST_ARMED;
          end else if (dec_trigger && (idx_inc == lat_trig_count)) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE:  state_next = ST_IDLE;
        ST_ERROR: state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and run counters
  always_comb begin
    trigger_next    = hit;
    done_next       = (state_next == ST_DONE);
    busy_next       = (state_next == ST_HOMING) || (state_next == ST_ARMED) ||
                      (state_next == ST_ACTIVE);
    error_next      = o_error;
    trig_index_next = o_trig_index;
    home_cnt_next   = home_cnt;
    if (start_ok) begin
      error_next      = 1'b0;
      trig_index_next = '0;
      home_cnt_next   = 32'd0;
    end else begin
      if (state_next == ST_ERROR) error_next = 1'b1;
      if (hit) trig_index_next = idx_inc;
      if ((state == ST_HOMING) && !i_abort && !win_invalid && !homed) begin
        home_cnt_next = home_cnt_inc;
      end
    end
  end

  // Output, counter and configuration registers
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_dec_enable     <= 1'b0;
      o_trigger        <= 1'b0;
      o_trig_index     <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
      home_cnt         <= 32'd0;
      lat_home_req     <= 1'b0;
      lat_home_timeout <= 32'd0;
      lat_win_start    <= '0;
      lat_win_stop     <= '0;
      lat_trig_count   <= '0;
    end else begin
      // Decoder stays enabled after the first run so position tracking persists
      o_dec_enable <= o_dec_enable | start_ok;
      o_trigger    <= trigger_next;
      o_trig_index <= trig_index_next;
      o_busy       <= busy_next;
      o_done       <= done_next;
      o_error      <= error_next;
      home_cnt     <= home_cnt_next;
      if (start_ok) begin
        lat_home_req     <= cfg_home_req;
        lat_home_timeout <= cfg_home_timeout;
        lat_win_start    <= cfg_win_start;
        lat_win_stop     <= cfg_win_stop;
        lat_trig_count   <= cfg_trig_count;
      end
    end
  end

endmodule

// File: tb/tb_encoder_trigger_sequencer.sv
// tb/tb_encoder_trigger_sequencer.sv - randomized and directed self-checking bench for the sequencer
import encoder_pkg::*;

module tb_encoder_trigger_sequencer;

  logic        i_clk = 1'b0;
  logic        i_aresetn = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic        cfg_home_req = 1'b0;
  logic [31:0] cfg_home_timeout = 32'd0;
  logic [31:0] cfg_win_start = 32'd0;
  logic [31:0] cfg_win_stop = 32'd0;
  logic [15:0] cfg_trig_count = 16'd0;
  logic        dec_zero_mark = 1'b0;
  logic        dec_trigger = 1'b0;
  logic [31:0] dec_position = 32'd0;
  logic        o_dec_enable;
  logic        o_trigger;
  logic [15:0] o_trig_index;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [2:0]  o_state;

  int passed = 0;
  int total = 0;
  bit cmp_en = 1'b0;
  int trig_seen = 0;
  int done_seen = 0;

  encoder_trigger_sequencer dut (
    .i_clk(i_clk), .i_aresetn(i_aresetn), .i_start(i_start), .i_abort(i_abort),
    .cfg_home_req(cfg_home_req), .cfg_home_timeout(cfg_home_timeout),
    .cfg_win_start(cfg_win_start), .cfg_win_stop(cfg_win_stop), .cfg_trig_count(cfg_trig_count),
    .dec_zero_mark(dec_zero_mark), .dec_trigger(dec_trigger), .dec_position(dec_position),
    .o_dec_enable(o_dec_enable), .o_trigger(o_trigger), .o_trig_index(o_trig_index),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference model: what each output must be after every clock edge
  seq_state_e  m_state = ST_IDLE;
  bit          m_en = 0, m_trig = 0, m_done = 0, m_err = 0, m_hr = 0;
  logic [15:0] m_idx = 0, m_tc = 0;
  logic [31:0] m_tmo = 0, m_hcyc = 0;
  int          m_ws = 0, m_we = 0;

  function automatic bit in_win(int p);
    return (p >= m_ws) && (p <= m_we);
  endfunction

  always @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      m_state = ST_IDLE; m_en = 0; m_trig = 0; m_done = 0; m_err = 0; m_hr = 0;
      m_idx = 0; m_tc = 0; m_tmo = 0; m_hcyc = 0; m_ws = 0; m_we = 0;
    end else begin
      m_trig = 0;
      m_done = 0;
      if (m_state == ST_IDLE) begin
        if (i_start && !i_abort) begin
          m_hr = cfg_home_req; m_tmo = cfg_home_timeout; m_tc = cfg_trig_count;
          m_ws = $signed(cfg_win_start); m_we = $signed(cfg_win_stop);
          m_err = 0; m_idx = 0; m_hcyc = 0; m_en = 1;
          m_state = ST_HOMING;
        end
      end else if (i_abort) begin
        m_state = ST_IDLE;
      end else begin
        case (m_state)
          ST_HOMING: begin
            if (m_ws > m_we) begin
              m_state = ST_ERROR; m_err = 1;
            end else if (!m_hr || dec_zero_mark) begin
              if (m_tc == 0) begin m_state = ST_DONE; m_done = 1; end
              else m_state = ST_ARMED;
            end else begin
              m_hcyc = m_hcyc + 1;
              if (m_tmo != 0 && m_hcyc == m_tmo) begin m_state = ST_ERROR; m_err = 1; end
            end
          end
          ST_ARMED: if (in_win($signed(dec_position))) m_state = ST_ACTIVE;
          ST_ACTIVE: begin
            if (!in_win($signed(dec_position))) m_state = ST_ARMED;
            else if (dec_trigger) begin
              m_trig = 1;
              m_idx = m_idx + 1;
              if (m_idx == m_tc) begin m_state = ST_DONE; m_done = 1; end
            end
          end
          default: m_state = ST_IDLE;
        endcase
      end
    end
  end

  // Compare every cycle, sampled on the falling edge
  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("outputs{state,en,trig,idx,busy,done,err}",
            {o_state, o_dec_enable, o_trigger, o_trig_index, o_busy, o_done, o_error},
            {m_state, m_en, m_trig, m_idx,
             (m_state == ST_HOMING || m_state == ST_ARMED || m_state == ST_ACTIVE), m_done, m_err});
      if (o_trigger) trig_seen++;
      if (o_done) done_seen++;
    end
  end

  task automatic set_cfg(input bit hr, input int unsigned tmo, input int ws, input int we, input int tc);
    cfg_home_req = hr; cfg_home_timeout = tmo;
    cfg_win_start = ws; cfg_win_stop = we; cfg_trig_count = 16'(tc);
  endtask

  // Entered and left on a falling edge; the start edge has passed on return
  task automatic start_run();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic drive(input int pos, input bit trig);
    dec_position = pos;
    dec_trigger = trig;
    @(negedge i_clk);
    dec_trigger = 1'b0;
  endtask

  initial begin
    int idle_at, t0, d0, pos;
    repeat (3) @(negedge i_clk);
    check("reset_outputs", {o_state, o_dec_enable, o_trigger, o_trig_index, o_busy, o_done, o_error}, 64'd0);
    i_aresetn = 1'b1;
    cmp_en = 1'b1;
    @(negedge i_clk);

    // Homing timeout of 100 with no zero mark
    set_cfg(1, 100, 0, 10, 2);
    dec_zero_mark = 0;
    t0 = trig_seen;
    idle_at = -1;
    start_run();
    for (int e = 1; e <= 300; e++) begin
      @(negedge i_clk);
      if (o_state == 3'(ST_IDLE)) begin idle_at = e; break; end
    end
    check("timeout_idle_cycle", idle_at, 101);
    check("timeout_error", o_error, 1);
    check("timeout_no_trigger", trig_seen - t0, 0);

    // Ramp through window [-10,50], three triggers wanted
    set_cfg(0, 0, -10, 50, 3);
    dec_position = 0;
    t0 = trig_seen; d0 = done_seen;
    start_run();
    for (int p = 1; p <= 60; p++) drive(p, (p == 5 || p == 20 || p == 40 || p == 55));
    check("ramp_triggers", trig_seen - t0, 3);
    check("ramp_done_pulses", done_seen - d0, 1);
    check("ramp_index", o_trig_index, 3);

    // Leave window [100,200] and come back
    set_cfg(0, 0, 100, 200, 4);
    dec_position = 150;
    d0 = done_seen;
    start_run();
    drive(150, 0); drive(150, 0);
    check("reenter_first_active", o_state, 3'(ST_ACTIVE));
    drive(150, 1); drive(150, 0); drive(150, 1);
    drive(250, 0);
    check("reenter_armed", {o_state, o_trig_index}, {3'(ST_ARMED), 16'd2});
    drive(250, 1); drive(150, 0);
    check("reenter_active_again", {o_state, o_trig_index}, {3'(ST_ACTIVE), 16'd2});
    drive(150, 1); drive(150, 1);
    check("reenter_done", {o_state, o_done, o_trig_index}, {3'(ST_DONE), 1'b1, 16'd4});
    drive(150, 0);
    check("reenter_idle", {o_state, o_busy}, {3'(ST_IDLE), 1'b0});
    check("reenter_done_pulses", done_seen - d0, 1);

    // Inverted window
    set_cfg(0, 0, 10, 5, 2);
    start_run();
    drive(0, 0);
    check("bad_window_error", {o_state, o_error}, {3'(ST_ERROR), 1'b1});
    drive(0, 0);
    check("bad_window_idle", {o_state, o_busy, o_error}, {3'(ST_IDLE), 1'b0, 1'b1});

    // Abort coincident with an in-window trigger
    set_cfg(0, 0, 0, 100, 5);
    dec_position = 50;
    start_run();
    drive(50, 0); drive(50, 0);
    i_abort = 1'b1;
    drive(50, 1);
    i_abort = 1'b0;
    check("abort_outputs{state,en,trig,done,busy,err}",
          {o_state, o_dec_enable, o_trigger, o_done, o_busy, o_error},
          {3'(ST_IDLE), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    // Asynchronous reset mid-ACTIVE, then a clean run
    start_run();
    drive(50, 0); drive(50, 0); drive(50, 1);
    check("pre_reset_index", o_trig_index, 1);
    #2 i_aresetn = 1'b0;
    #1 check("async_reset_outputs",
             {o_state, o_dec_enable, o_trigger, o_trig_index, o_busy, o_done, o_error}, 64'd0);
    @(negedge i_clk);
    i_aresetn = 1'b1;
    start_run();
    drive(50, 0); drive(50, 0); drive(50, 1);
    check("post_reset_index", {o_trigger, o_trig_index}, {1'b1, 16'd1});
    i_abort = 1'b1;
    drive(50, 0);
    i_abort = 1'b0;

    // Randomized traffic against the model
    pos = 0;
    for (int c = 0; c < 3000; c++) begin
      int ws;
      ws = int'($urandom_range(0, 50)) - 20;
      set_cfg($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
              ws, ws + int'($urandom_range(0, 45)) - 5, $urandom_range(0, 4));
      i_start = ($urandom_range(0, 3) == 0);
      i_abort = ($urandom_range(0, 49) == 0);
      dec_zero_mark = ($urandom_range(0, 7) == 0);
      pos = pos + int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 19) == 0) pos = int'($urandom_range(0, 100)) - 30;
      if (pos < -40) pos = -40;
      if (pos > 80) pos = 80;
      dec_position = pos;
      dec_trigger = ($urandom_range(0, 2) == 0);
      @(negedge i_clk);
    end
    i_start = 0; i_abort = 0; dec_trigger = 0;
    @(negedge i_clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
